shake_squeeze: RTL and testbench

Squeeze-side output stage for the SHAKE/Keccak datapath. It captures the rate portion of the 1600-bit permutation state when the permutation reports completion. It streams that portion out as 64-bit lanes over a valid/ready interface, and requests further permutations until the requested number of output words has been delivered. It sits directly downstream of the `shake` permutation core (`state_out`/`valid`) and drives that core's `enable` for every squeeze block after the first.

---
 rtl/shake_squeeze_if.sv | 18 +
 rtl/shake_squeeze.sv | 142 ++++++++++++++
 tb/tb_shake_squeeze.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shake_squeeze_if.sv
// Squeeze output stream: 64-bit Keccak lanes over a valid/ready handshake.
interface shake_squeeze_if;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/shake_squeeze.sv
// SHAKE squeeze stage: captures the rate part of the Keccak state and
// streams it as 64-bit lanes, requesting permutations until len_words sent.
module shake_squeeze #(
  parameter int RATE_BYTES = 168
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [15:0]     len_words,
  input  logic [1599:0]   state_in,
  input  logic            state_valid,
  output logic            perm_req,
  output logic            done,
  output logic            busy,
  shake_squeeze_if.master out_if
);

  localparam int RATE_LANES = RATE_BYTES / 8;
  localparam int RATE_BITS  = RATE_BYTES * 8;
  localparam int IDX_W =
    (RATE_LANES > 1) ? $clog2(RATE_LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_LANE =
    IDX_W'(RATE_LANES - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PERM,
    STREAM,
    REQ,
    DONE
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [RATE_BITS-1:0] rate_buf;
  logic [IDX_W-1:0]     lane_idx;
  logic [15:0]          remaining;
  logic                 zero_done;

  logic fire;
  logic capture;
  logic launch;
  logic zero_len;
  logic last_word;
  logic last_lane;

  assign fire      = (state_q == STREAM) && out_if.out_ready;
  assign last_word = (remaining == 16'd1);
  assign last_lane = (lane_idx == LAST_LANE);

  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    launch   = 1'b0;
    zero_len = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (len_words == 16'd0) begin
            zero_len = 1'b1;
          end else begin
            launch  = 1'b1;
            capture = state_valid;
            state_d = state_valid ? STREAM : WAIT_PERM;
          end
        end
      end
      WAIT_PERM: begin
        if (state_valid) begin
          capture = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (fire) begin
          if (last_word) begin
            state_d = DONE;
          end else if (last_lane) begin
            state_d = REQ;
          end
        end
      end
      REQ:     state_d = WAIT_PERM;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      zero_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      zero_done <= zero_len;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rate_buf <= '0;
    end else if (capture) begin
      rate_buf <= state_in[RATE_BITS-1:0];
    end
  end

  // lane_idx only rewinds on a load or capture; after the last lane
  // it parks there until the next state arrives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_idx  <= '0;
      remaining <= '0;
    end else begin
      if (launch) begin
        remaining <= len_words;
      end else if (fire) begin
        remaining <= remaining - 16'd1;
      end
      if (launch || capture) begin
        lane_idx <= '0;
      end else if (fire && !last_word && !last_lane) begin
        lane_idx <= lane_idx + IDX_W'(1);
      end
    end
  end

  assign out_if.out_valid = (state_q == STREAM);
  assign out_if.out_data  =
    rate_buf[32'(lane_idx) * 64 +: 64];
  assign perm_req = (state_q == REQ);
  assign done     = (state_q == DONE) || zero_done;
  assign busy     = (state_q != IDLE);

  // Capacity lanes never enter the datapath.
  generate
    if (RATE_BITS < 1600) begin : g_cap
      logic unused_cap;
      assign unused_cap = ^state_in[1599:RATE_BITS];
    end
  endgenerate

endmodule

// File: tb/tb_shake_squeeze.sv
// Scoreboard bench for shake_squeeze: random blocks and backpressure,
// expected words derived from the rate-lane slicing rule.
module tb_shake_squeeze;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int n_tests = 0;
  int n_fail  = 0;

  logic          start_a = 1'b0;
  logic [15:0]   len_a   = '0;
  logic [1599:0] st_a    = '0;
  logic          sv_a    = 1'b0;
  logic          perm_a, done_a, busy_a;
  shake_squeeze_if ifa();

  shake_squeeze #(.RATE_BYTES(168)) dut_a (
    .clk(clk), .rst(rst_n), .start(start_a),
    .len_words(len_a), .state_in(st_a),
    .state_valid(sv_a), .perm_req(perm_a),
    .done(done_a), .busy(busy_a), .out_if(ifa)
  );

  logic          start_b = 1'b0;
  logic [15:0]   len_b   = '0;
  logic [1599:0] st_b    = '0;
  logic          sv_b    = 1'b0;
  logic          perm_b, done_b, busy_b;
  shake_squeeze_if ifb();

  shake_squeeze #(.RATE_BYTES(136)) dut_b (
    .clk(clk), .rst(rst_n), .start(start_b),
    .len_words(len_b), .state_in(st_b),
    .state_valid(sv_b), .perm_req(perm_b),
    .done(done_b), .busy(busy_b), .out_if(ifb)
  );

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  bit rnd_a = 1'b0;
  always @(posedge clk) begin
    #1;
    ifa.out_ready = rnd_a ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  logic [63:0] exp_a[$];
  logic [63:0] exp_b[$];
  int xfer_a, nperm_a, ndone_a, left_a;
  int xfer_b, nperm_b, ndone_b, left_b;
  bit stall_a = 1'b0;
  bit pperm_a = 1'b0;
  bit pdone_a = 1'b0;
  logic [63:0] held_a;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_a = 1'b0;
      pperm_a = 1'b0;
      pdone_a = 1'b0;
    end else begin
      if (stall_a) begin
        chk("a_hold_valid", 64'(ifa.out_valid), 64'd1);
        chk("a_hold_data", ifa.out_data, held_a);
      end
      stall_a = 1'b0;
      if (ifa.out_valid && ifa.out_ready) begin
        xfer_a++;
        if (exp_a.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL a_extra: got %h want none",
                   ifa.out_data);
        end else begin
          chk("a_word", ifa.out_data, exp_a.pop_front());
        end
      end else if (ifa.out_valid) begin
        stall_a = 1'b1;
        held_a  = ifa.out_data;
      end
      if (perm_a) begin
        nperm_a++;
        chk("a_perm_pulse", 64'(pperm_a), 64'd0);
      end
      if (done_a) begin
        ndone_a++;
        chk("a_done_pulse", 64'(pdone_a), 64'd0);
      end
      pperm_a = perm_a;
      pdone_a = done_a;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (ifb.out_valid && ifb.out_ready) begin
        xfer_b++;
        if (exp_b.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL b_extra: got %h want none",
                   ifb.out_data);
        end else begin
          chk("b_word", ifb.out_data, exp_b.pop_front());
        end
      end
      if (perm_b) begin
        nperm_b++;
        chk("b_perm_after", xfer_b, 17);
      end
      if (done_b) ndone_b++;
    end
  end

  // Model: each state contributes its first min(left, lanes) rate lanes.
  task automatic give_a(int mode, int blk);
    logic [63:0] w;
    for (int i = 0; i < 25; i++) begin
      if (mode == 1 && blk == 0)
        w = (i == 0) ? 64'hecfcfdba740b56bc : {8{8'(i)}};
      else if (mode == 1)
        w = {8{8'(8'hA0 + i)}};
      else
        w = {$urandom, $urandom};
      st_a[i*64 +: 64] = w;
      if (i < 21 && left_a > 0) begin
        exp_a.push_back(w);
        left_a--;
      end
    end
    sv_a = 1'b1;
  endtask

  task automatic give_b();
    logic [63:0] w;
    for (int i = 0; i < 25; i++) begin
      w = {$urandom, $urandom};
      st_b[i*64 +: 64] = w;
      if (i < 17 && left_b > 0) begin
        exp_b.push_back(w);
        left_b--;
      end
    end
    sv_b = 1'b1;
  endtask

  task automatic session_a(int len, int mode, bit same,
                           bit rnd, bit poke);
    int blk = 0;
    int cyc = 0;
    bit fin = 1'b0;
    rnd_a  = rnd;
    xfer_a = 0;
    nperm_a = 0;
    ndone_a = 0;
    left_a = len;
    @(posedge clk); #1;
    start_a = 1'b1;
    len_a   = 16'(len);
    if (same && len != 0) begin
      give_a(mode, blk);
      blk++;
    end
    @(posedge clk); #1;
    start_a = 1'b0;
    sv_a    = 1'b0;
    if (len == 0) begin
      @(negedge clk);
      chk("z_done", 64'(done_a), 64'd1);
      chk("z_busy", 64'(busy_a), 64'd0);
      @(negedge clk);
      chk("z_done_clr", 64'(done_a), 64'd0);
      chk("z_valid", 64'(ifa.out_valid), 64'd0);
      chk("z_dones", ndone_a, 1);
      chk("z_xfers", xfer_a, 0);
      return;
    end
    if (!same) begin
      repeat (2) @(posedge clk);
      #1;
      chk("a_wait_busy", 64'(busy_a), 64'd1);
      give_a(mode, blk);
      blk++;
      @(posedge clk); #1;
      sv_a = 1'b0;
    end
    @(negedge clk);
    chk("a_valid_lat", 64'(ifa.out_valid), 64'd1);
    if (poke) begin
      @(posedge clk); #1;
      start_a = 1'b1;
      len_a   = 16'd5;
      sv_a    = 1'b1;
      st_a    = {50{$urandom}};
      @(posedge clk); #1;
      start_a = 1'b0;
      sv_a    = 1'b0;
    end
    while (!fin && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (perm_a) begin
        chk("a_req_valid", 64'(ifa.out_valid), 64'd0);
        repeat (3) begin
          @(negedge clk);
          chk("a_wait_valid", 64'(ifa.out_valid), 64'd0);
        end
        @(posedge clk); #1;
        give_a(mode, blk);
        blk++;
        @(posedge clk); #1;
        sv_a = 1'b0;
        @(negedge clk);
        chk("a_valid_lat", 64'(ifa.out_valid), 64'd1);
      end else if (done_a) begin
        fin = 1'b1;
      end
    end
    if (!fin) begin
      n_tests++;
      n_fail++;
      $display("FAIL a_timeout: got no done want done len=%0d",
               len);
    end
    @(negedge clk);
    chk("a_xfers", xfer_a, len);
    chk("a_perms", nperm_a, (len + 20) / 21 - 1);
    chk("a_dones", ndone_a, 1);
    chk("a_leftover", exp_a.size(), 0);
    chk("a_done_clr", 64'(done_a), 64'd0);
    chk("a_idle", 64'(busy_a), 64'd0);
    exp_a.delete();
  endtask

  task automatic reset_mid();
    int cyc = 0;
    rnd_a  = 1'b0;
    xfer_a = 0;
    left_a = 10;
    @(posedge clk); #1;
    start_a = 1'b1;
    len_a   = 16'd10;
    give_a(0, 0);
    @(posedge clk); #1;
    start_a = 1'b0;
    sv_a    = 1'b0;
    while (xfer_a < 3 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", 64'(ifa.out_valid), 64'd0);
    chk("rst_data", ifa.out_data, 64'd0);
    chk("rst_perm", 64'(perm_a), 64'd0);
    chk("rst_done", 64'(done_a), 64'd0);
    chk("rst_busy", 64'(busy_a), 64'd0);
    exp_a.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic session_b();
    int cyc = 0;
    left_b  = 18;
    xfer_b  = 0;
    nperm_b = 0;
    ndone_b = 0;
    @(posedge clk); #1;
    start_b = 1'b1;
    len_b   = 16'd18;
    give_b();
    @(posedge clk); #1;
    start_b = 1'b0;
    sv_b    = 1'b0;
    while (!perm_b && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("b_perm_seen", 64'(perm_b), 64'd1);
    @(posedge clk); #1;
    give_b();
    @(posedge clk); #1;
    sv_b = 1'b0;
    cyc  = 0;
    while (!done_b && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("b_done_seen", 64'(done_b), 64'd1);
    @(negedge clk);
    chk("b_xfers", xfer_b, 18);
    chk("b_perms", nperm_b, 1);
    chk("b_dones", ndone_b, 1);
    chk("b_leftover", exp_b.size(), 0);
    chk("b_idle", 64'(busy_b), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    ifb.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst0_valid", 64'(ifa.out_valid), 64'd0);
    chk("rst0_data", ifa.out_data, 64'd0);
    chk("rst0_perm", 64'(perm_a), 64'd0);
    chk("rst0_done", 64'(done_a), 64'd0);
    chk("rst0_busy", 64'(busy_a), 64'd0);
    chk("rst0_b_valid", 64'(ifb.out_valid), 64'd0);
    chk("rst0_b_busy", 64'(busy_b), 64'd0);
    rst_n = 1'b1;

    session_a(4, 1, 1'b0, 1'b0, 1'b0);
    session_a(25, 1, 1'b0, 1'b0, 1'b0);
    session_a(30, 0, 1'b0, 1'b1, 1'b0);
    session_a(0, 0, 1'b0, 1'b0, 1'b0);
    session_a(30, 0, 1'b0, 1'b1, 1'b1);
    session_a(5, 0, 1'b1, 1'b0, 1'b0);
    reset_mid();
    session_a(2, 0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      session_a($urandom_range(1, 70), 0,
                1'($urandom_range(0, 1)), 1'b1, 1'b0);
    end
    session_b();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
